// File: rtl/pong_pkg.sv
// Shared encodings and default timing/geometry constants for the pong game blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    localparam int DEF_TICK_DIV     = 1000000;
    localparam int DEF_HOLD_TICKS   = 30;
    localparam int DEF_REPEAT_TICKS = 5;
    localparam int DEF_STEP         = 4;
    localparam int DEF_Y_MIN        = 0;
    localparam int DEF_Y_MAX        = 400;
    localparam int DEF_Y_INIT       = 200;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_gen
    import pong_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: immediate move on press, then hold delay and auto-repeat.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int STEP         = DEF_STEP,
    parameter int Y_MIN        = DEF_Y_MIN,
    parameter int Y_MAX        = DEF_Y_MAX,
    parameter int Y_INIT       = DEF_Y_INIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up_db,
    input  logic       down_db,
    input  logic       freeze,
    output logic [9:0] paddle_y,
    output logic       move_pulse,
    output logic       at_top,
    output logic       at_bottom
);

    localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    // Signed 12-bit math so y - STEP near the top cannot wrap before the clamp.
    function automatic logic [9:0] step_y(input logic [9:0] y, input dir_t d);
        logic signed [11:0] y_s;
        logic signed [11:0] nxt;
        y_s = $signed({2'b00, y});
        nxt = y_s;
        if (d == DIR_UP) begin
            nxt = y_s - STEP_S;
            if (nxt < Y_MIN_S) nxt = Y_MIN_S;
        end else if (d == DIR_DN) begin
            nxt = y_s + STEP_S;
            if (nxt > Y_MAX_S) nxt = Y_MAX_S;
        end
        return nxt[9:0];
    endfunction

    state_t           state, state_n;
    dir_t             dir, dir_q;
    logic [CNT_W-1:0] hold_cnt, cnt_n, cnt_inc;
    logic             tick, press, do_move;
    logic [9:0]       y_next;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        dir = DIR_NONE;
        if (up_db && !down_db)      dir = DIR_UP;
        else if (down_db && !up_db) dir = DIR_DN;
    end

    assign press   = (dir != DIR_NONE) && (dir != dir_q);
    assign cnt_inc = hold_cnt + CNT_W'(1);
    assign y_next  = step_y(paddle_y, dir);

    always_comb begin
        state_n = state;
        cnt_n   = hold_cnt;
        do_move = 1'b0;
        if (freeze) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else if (press) begin
            do_move = 1'b1;
            cnt_n   = '0;
            state_n = S_HOLD;
        end else begin
            unique case (state)
                S_HOLD, S_REPEAT: begin
                    if (dir == DIR_NONE) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else if (tick) begin
                        // Same counter serves both phases; only the terminal count differs.
                        if (cnt_inc == ((state == S_HOLD) ? CNT_W'(HOLD_TICKS) : CNT_W'(REPEAT_TICKS))) begin
                            do_move = 1'b1;
                            cnt_n   = '0;
                            state_n = S_REPEAT;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            dir_q      <= DIR_NONE;
            hold_cnt   <= '0;
            paddle_y   <= 10'(Y_INIT);
            move_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            dir_q      <= dir;
            hold_cnt   <= cnt_n;
            if (do_move) paddle_y <= y_next;
            move_pulse <= do_move && (y_next != paddle_y);
        end
    end

    assign at_top    = (paddle_y == 10'(Y_MIN));
    assign at_bottom = (paddle_y == 10'(Y_MAX));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with a fast tick (TICK_DIV=4, HOLD=3, REPEAT=2).
module tb_paddle_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       up_db = 1'b0;
    logic       down_db = 1'b0;
    logic       freeze = 1'b0;
    logic [9:0] paddle_y, y2;
    logic       move_pulse, at_top, at_bottom;
    logic       pulse2, top2, bot2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    paddle_ctrl #(
        .TICK_DIV(4), .HOLD_TICKS(3), .REPEAT_TICKS(2), .STEP(4),
        .Y_MIN(0), .Y_MAX(400), .Y_INIT(200)
    ) dut (
        .clock(clock), .reset(reset), .up_db(up_db), .down_db(down_db), .freeze(freeze),
        .paddle_y(paddle_y), .move_pulse(move_pulse), .at_top(at_top), .at_bottom(at_bottom)
    );

    // Second instance starts near the limits to exercise clamping.
    paddle_ctrl #(
        .TICK_DIV(4), .HOLD_TICKS(3), .REPEAT_TICKS(2), .STEP(4),
        .Y_MIN(0), .Y_MAX(8), .Y_INIT(2)
    ) dut_edge (
        .clock(clock), .reset(reset), .up_db(up_db), .down_db(down_db), .freeze(freeze),
        .paddle_y(y2), .move_pulse(pulse2), .at_top(top2), .at_bottom(bot2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        up_db   = 1'b0;
        down_db = 1'b0;
        freeze  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        tests++; if (paddle_y !== 10'd200) begin fails++; $display("FAIL reset_y: got %0d expected 200", paddle_y); end
        tests++; if (move_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b expected 0", move_pulse); end
        tests++; if (at_top !== 1'b0 || at_bottom !== 1'b0) begin fails++; $display("FAIL reset_flags: got top=%b bot=%b expected 0 0", at_top, at_bottom); end
        tests++; if (y2 !== 10'd2) begin fails++; $display("FAIL reset_y_edge: got %0d expected 2", y2); end
        up_db = 1'b1;
        step();
        step();
        tests++; if (paddle_y !== 10'd200) begin fails++; $display("FAIL reset_hold_y: got %0d expected 200", paddle_y); end
        reset = 1'b0;
        step();
        tests++; if (paddle_y !== 10'd196) begin fails++; $display("FAIL reset_release_press: got %0d expected 196", paddle_y); end
        tests++; if (move_pulse !== 1'b1) begin fails++; $display("FAIL reset_release_pulse: got %b expected 1", move_pulse); end
        up_db = 1'b0;
        step();
    endtask

    task automatic test_single_press();
        int pcount;
        do_reset();
        up_db = 1'b1;
        step();
        tests++; if (paddle_y !== 10'd196) begin fails++; $display("FAIL single_y: got %0d expected 196", paddle_y); end
        tests++; if (move_pulse !== 1'b1) begin fails++; $display("FAIL single_pulse: got %b expected 1", move_pulse); end
        up_db = 1'b0;
        step();
        tests++; if (move_pulse !== 1'b0) begin fails++; $display("FAIL single_pulse_width: got %b expected 0", move_pulse); end
        pcount = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (move_pulse) pcount++;
        end
        tests++; if (pcount !== 0) begin fails++; $display("FAIL single_idle_pulses: got %0d expected 0", pcount); end
        tests++; if (paddle_y !== 10'd196) begin fails++; $display("FAIL single_idle_y: got %0d expected 196", paddle_y); end
    endtask

    task automatic test_hold_repeat();
        logic [9:0] exp_y;
        logic       mv;
        int         pcount;
        do_reset();
        exp_y  = 10'd200;
        pcount = 0;
        down_db = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            mv = (k == 1) || (k == 12) || (k == 20) || (k == 28) || (k == 36);
            if (mv) exp_y = exp_y + 10'd4;
            tests++; if (paddle_y !== exp_y) begin fails++; $display("FAIL hold_y edge %0d: got %0d expected %0d", k, paddle_y, exp_y); end
            tests++; if (move_pulse !== mv) begin fails++; $display("FAIL hold_pulse edge %0d: got %b expected %b", k, move_pulse, mv); end
            if (move_pulse) pcount++;
        end
        down_db = 1'b0;
        repeat (10) step();
        tests++; if (paddle_y !== 10'd220) begin fails++; $display("FAIL hold_release_y: got %0d expected 220", paddle_y); end
        tests++; if (pcount !== 5) begin fails++; $display("FAIL hold_pulse_count: got %0d expected 5", pcount); end
    endtask

    task automatic test_clamp();
        do_reset();
        up_db = 1'b1;
        step();
        tests++; if (y2 !== 10'd0) begin fails++; $display("FAIL clamp_top_y: got %0d expected 0", y2); end
        tests++; if (top2 !== 1'b1) begin fails++; $display("FAIL clamp_at_top: got %b expected 1", top2); end
        tests++; if (pulse2 !== 1'b1) begin fails++; $display("FAIL clamp_top_pulse: got %b expected 1", pulse2); end
        up_db = 1'b0;
        step();
        up_db = 1'b1;
        step();
        tests++; if (y2 !== 10'd0 || pulse2 !== 1'b0) begin fails++; $display("FAIL clamp_top_again: got y=%0d pulse=%b expected y=0 pulse=0", y2, pulse2); end
        up_db = 1'b0;
        step();
        down_db = 1'b1;
        step();
        tests++; if (y2 !== 10'd4 || pulse2 !== 1'b1 || top2 !== 1'b0) begin fails++; $display("FAIL clamp_down1: got y=%0d pulse=%b top=%b expected y=4 pulse=1 top=0", y2, pulse2, top2); end
        down_db = 1'b0;
        step();
        down_db = 1'b1;
        step();
        tests++; if (y2 !== 10'd8 || bot2 !== 1'b1 || pulse2 !== 1'b1) begin fails++; $display("FAIL clamp_bottom: got y=%0d bot=%b pulse=%b expected y=8 bot=1 pulse=1", y2, bot2, pulse2); end
        down_db = 1'b0;
        step();
        down_db = 1'b1;
        step();
        tests++; if (y2 !== 10'd8 || pulse2 !== 1'b0) begin fails++; $display("FAIL clamp_bottom_again: got y=%0d pulse=%b expected y=8 pulse=0", y2, pulse2); end
        down_db = 1'b0;
        step();
    endtask

    task automatic test_both_and_switch();
        int bad;
        logic [9:0] exp_y;
        do_reset();
        up_db   = 1'b1;
        down_db = 1'b1;
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (paddle_y !== 10'd200 || move_pulse !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL both_no_move: got %0d bad cycles expected 0", bad); end
        down_db = 1'b0;
        step();
        tests++; if (paddle_y !== 10'd196 || move_pulse !== 1'b1) begin fails++; $display("FAIL switch_up: got y=%0d pulse=%b expected y=196 pulse=1", paddle_y, move_pulse); end
        repeat (3) step();
        up_db   = 1'b0;
        down_db = 1'b1;
        step();
        tests++; if (paddle_y !== 10'd200 || move_pulse !== 1'b1) begin fails++; $display("FAIL switch_dn: got y=%0d pulse=%b expected y=200 pulse=1", paddle_y, move_pulse); end
        for (int k = 16; k <= 24; k++) begin
            step();
            exp_y = (k == 24) ? 10'd204 : 10'd200;
            tests++; if (paddle_y !== exp_y) begin fails++; $display("FAIL switch_restart edge %0d: got %0d expected %0d", k, paddle_y, exp_y); end
        end
        down_db = 1'b0;
        step();
    endtask

    task automatic test_freeze();
        int bad;
        do_reset();
        down_db = 1'b1;
        repeat (20) step();
        tests++; if (paddle_y !== 10'd212) begin fails++; $display("FAIL freeze_pre_y: got %0d expected 212", paddle_y); end
        step();
        freeze = 1'b1;
        bad = 0;
        for (int k = 22; k <= 40; k++) begin
            step();
            if (paddle_y !== 10'd212 || move_pulse !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL freeze_hold: got %0d bad cycles expected 0", bad); end
        freeze = 1'b0;
        bad = 0;
        for (int k = 41; k <= 60; k++) begin
            step();
            if (paddle_y !== 10'd212 || move_pulse !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL freeze_release_no_press: got %0d bad cycles expected 0", bad); end
        down_db = 1'b0;
        step();
        down_db = 1'b1;
        step();
        tests++; if (paddle_y !== 10'd216 || move_pulse !== 1'b1) begin fails++; $display("FAIL freeze_new_press: got y=%0d pulse=%b expected y=216 pulse=1", paddle_y, move_pulse); end
        down_db = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_repeat();
        do_reset();
        down_db = 1'b1;
        repeat (20) step();
        tests++; if (paddle_y !== 10'd212 || move_pulse !== 1'b1) begin fails++; $display("FAIL mid_pre: got y=%0d pulse=%b expected y=212 pulse=1", paddle_y, move_pulse); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (paddle_y !== 10'd200) begin fails++; $display("FAIL mid_async_y: got %0d expected 200", paddle_y); end
        tests++; if (move_pulse !== 1'b0) begin fails++; $display("FAIL mid_async_pulse: got %b expected 0", move_pulse); end
        down_db = 1'b0;
        up_db   = 1'b1;
        step();
        reset = 1'b0;
        step();
        tests++; if (paddle_y !== 10'd196 || move_pulse !== 1'b1) begin fails++; $display("FAIL mid_release_press: got y=%0d pulse=%b expected y=196 pulse=1", paddle_y, move_pulse); end
        up_db = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_clamp();
        test_both_and_switch();
        test_freeze();
        test_reset_mid_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- TICK_DIV, 1000000, clocks per timing tick (10 ms at 100 MHz).
- HOLD_TICKS, 30, ticks of hold before auto-repeat starts.
- REPEAT_TICKS, 5, ticks between auto-repeat moves.
- STEP, 4, pixels per move.
- Y_MIN, 0, top limit.
- Y_MAX, 400, bottom limit.
- Y_INIT, 200, reset position.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- up_db  input  1  debounced up button, synchronous to clock.
- down_db  input  1  debounced down button, synchronous to clock.
- freeze  input  1  suspends all movement when high.
- paddle_y  output  10  paddle top coordinate, registered.
- move_pulse  output  1  one-cycle strobe on every change of paddle_y.
- at_top  output  1  high when paddle_y == Y_MIN.
- at_bottom  output  1  high when paddle_y == Y_MAX.
REQ-003 SHALL use reset as asynchronous, active-high, and clock as the only clock.

Function
REQ-004 SHALL derive dir each cycle: UP = up_db & ~down_db; DN = down_db & ~up_db; NONE otherwise, including both high.
REQ-005 SHALL register dir as dir_q; a press event SHALL occur when dir != NONE and dir != dir_q, so UP->DN is a new press.
REQ-006 SHALL generate tick as a one-cycle pulse when a free-running counter reaches TICK_DIV-1, then wrap the counter to 0.
REQ-007 SHALL implement the FSM states IDLE, HOLD and REPEAT.
REQ-008 IDLE: a press event SHALL perform one move at the next edge, clear hold_cnt and go to HOLD.
REQ-009 HOLD: hold_cnt SHALL increment on each tick. When the tick brings hold_cnt to HOLD_TICKS, the block SHALL move once, clear hold_cnt and go to REPEAT. The first tick after a press MAY arrive 0 to 1 tick periods late, so the hold delay is (HOLD_TICKS-1) to HOLD_TICKS tick periods.
REQ-010 REPEAT: the block SHALL move once every REPEAT_TICKS ticks, using the same counter.
REQ-011 In HOLD or REPEAT, dir == NONE SHALL return to IDLE at the next edge with no move.
REQ-012 In HOLD or REPEAT, a new press event (direction change) SHALL be handled as in IDLE: immediate move and restart in HOLD.
REQ-013 An UP move SHALL set paddle_y = max(paddle_y-STEP, Y_MIN). A DN move SHALL set paddle_y = min(paddle_y+STEP, Y_MAX). The subtraction SHALL be evaluated without unsigned wrap.
REQ-014 move_pulse SHALL be high for exactly the cycle after paddle_y changes, registered alongside it. A move clamped to no change SHALL NOT pulse.
REQ-015 freeze high SHALL force IDLE, hold paddle_y and suppress move_pulse. dir_q SHALL keep tracking, so a button already held when freeze falls produces no press.
REQ-016 at_top and at_bottom SHALL be combinational compares of the registered paddle_y.
REQ-017 Movement latency from the press edge on the input to paddle_y updating SHALL be exactly 1 clock.

Reset
REQ-018 On reset: paddle_y = Y_INIT, move_pulse = 0, state = IDLE, dir_q = NONE, hold_cnt = 0, tick counter = 0. A button already held at reset release SHALL register as a press on the first clock.
REQ-019 Reset asserted mid-HOLD or mid-REPEAT SHALL abandon the sequence immediately, with no partial move.

Structure
REQ-020 The state encoding, the dir encoding (NONE/UP/DN) and the default parameter values SHALL live in the shared package pong_pkg.
REQ-021 The tick counter SHALL be a sub-module tick_gen (parameter TICK_DIV; ports clock, reset, tick). paddle_ctrl SHALL instantiate it once.
REQ-022 hold_cnt width SHALL be clog2(max(HOLD_TICKS, REPEAT_TICKS)+1).

Verification (TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2, STEP=4, Y_INIT=200)
REQ-023 Single press: up_db high for 1 clock -> paddle_y 196 one clock later, one move_pulse, FSM back to IDLE.
REQ-024 Hold: down_db held for 40 clocks -> 204 immediately, next move after 3 ticks, then every 8 clocks; move_pulse count equals the number of moves.
REQ-025 Clamp: start at Y_MIN+2 and press up -> paddle_y = 0, at_top = 1, one pulse; press up again -> no pulse.
REQ-026 Both buttons / direction switch: up and down both high -> no move. Holding up then switching directly to down -> immediate +4 and hold restart.
REQ-027 freeze: assert during REPEAT -> paddle_y constant and no pulses. Release freeze with down still held -> still no move until a new press.
REQ-028 Reset mid-REPEAT: paddle_y returns to 200 asynchronously and move_pulse = 0. Up held through reset release -> 196 on the first clock after release.
